// File: rtl/palette_pkg.sv
// ---------------------------------------------------------------------------
// palette_pkg
// Shared definitions for the palette colour mapper:
//   - rgb_t           : {r,g,b} colour record at the package channel width
//   - COL_* indices   : well-known palette slots (COL_BG is the blink background)
//   - default_level() : default palette expressed as per-channel levels
//                       (zero / half / max), so each module can scale the
//                       defaults to its own CHAN_W.
// ---------------------------------------------------------------------------
package palette_pkg;

  localparam int PAL_CHAN_W = 8;

  typedef struct packed {
    logic [PAL_CHAN_W-1:0] r;
    logic [PAL_CHAN_W-1:0] g;
    logic [PAL_CHAN_W-1:0] b;
  } rgb_t;

  localparam int COL_BG    = 0;
  localparam int COL_RED   = 1;
  localparam int COL_GREEN = 2;
  localparam int COL_BLUE  = 3;
  localparam int COL_OLIVE = 4;

  // Channel selectors for default_level()
  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  // Channel intensity levels of the default palette
  localparam logic [1:0] LVL_ZERO = 2'd0;
  localparam logic [1:0] LVL_HALF = 2'd1;
  localparam logic [1:0] LVL_MAX  = 2'd2;

  // Default palette: bg white, red, green, blue, olive, everything else white.
  function automatic logic [1:0] default_level(input int idx, input int ch);
    logic [1:0] lvl;
    lvl = LVL_MAX;
    case (idx)
      COL_RED:   lvl = (ch == CH_R) ? LVL_MAX : LVL_ZERO;
      COL_GREEN: lvl = (ch == CH_G) ? LVL_MAX : LVL_ZERO;
      COL_BLUE:  lvl = (ch == CH_B) ? LVL_MAX : LVL_ZERO;
      COL_OLIVE: lvl = (ch == CH_B) ? LVL_ZERO : LVL_HALF;
      default:   lvl = LVL_MAX;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/palette_regfile.sv
// ---------------------------------------------------------------------------
// palette_regfile
// Double-buffered palette storage. Writes land in the shadow copy; the
// active copy (the one the pixel pipeline reads) is refreshed from the
// shadow in one shot on commit, so a frame never sees a half-written palette.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (both copies -> defaults)
//   commit       frame-start pulse: active <= shadow, writes held off
//   wr_valid     write request
//   wr_ready     write accepted when wr_valid && wr_ready (low on commit)
//   wr_idx       entry to write
//   wr_rgb       {R,G,B} value to write
//   rd_idx       combinational read index into the active palette
//   rd_rgb       {R,G,B} of active[rd_idx]
// ---------------------------------------------------------------------------
module palette_regfile
  import palette_pkg::*;
#(
  parameter  int IDX_W      = 3,
  parameter  int CHAN_W     = 8,
  localparam int NUM_COLORS = 2 ** IDX_W,
  localparam int RGB_W      = 3 * CHAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [RGB_W-1:0] wr_rgb,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [RGB_W-1:0] rd_rgb
);

  function automatic logic [CHAN_W-1:0] level_value(input logic [1:0] lvl);
    logic [CHAN_W-1:0] max_v;
    logic [CHAN_W-1:0] val;
    max_v = {CHAN_W{1'b1}};
    case (lvl)
      LVL_MAX:  val = max_v;
      LVL_HALF: val = max_v >> 1;
      default:  val = '0;
    endcase
    return val;
  endfunction

  function automatic logic [RGB_W-1:0] default_entry(input int idx);
    return {level_value(default_level(idx, CH_R)),
            level_value(default_level(idx, CH_G)),
            level_value(default_level(idx, CH_B))};
  endfunction

  logic [NUM_COLORS-1:0][RGB_W-1:0] defaults;
  logic [RGB_W-1:0]                 shadow [NUM_COLORS];
  logic [RGB_W-1:0]                 active [NUM_COLORS];
  logic                             wr_fire;

  for (genvar gi = 0; gi < NUM_COLORS; gi++) begin : g_default
    assign defaults[gi] = default_entry(gi);
  end

  // The commit cycle refuses writes, so a shadow update and a commit never
  // coincide and the copy is always a consistent snapshot.
  assign wr_ready = ~commit;
  assign wr_fire  = wr_valid & wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COLORS; i++) begin
        shadow[i] <= defaults[i];
        active[i] <= defaults[i];
      end
    end else begin
      if (wr_fire) begin
        shadow[wr_idx] <= wr_rgb;
      end
      if (commit) begin
        for (int i = 0; i < NUM_COLORS; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  assign rd_rgb = active[rd_idx];

endmodule

// File: rtl/palette_color_mapper.sv
// ---------------------------------------------------------------------------
// palette_color_mapper
// Converts a per-pixel colour index into registered VGA RGB through a
// run-time-programmable, double-buffered palette with per-index blinking.
// Two-stage pipeline: index in at cycle t, RGB out at cycle t+2, no stalls.
//
// Optional build macro: PALETTE_GRID_LINES_EN
//   defined   -> pixels on a CELL_SIZE grid line get every channel halved
//   undefined -> no grid logic, DrawX/DrawY/CELL_SIZE unused
//
// Ports:
//   Clk, Reset_n      pixel clock, asynchronous active-low reset
//   color             colour index of current pixel
//   DrawX, DrawY      current pixel coordinates (grid feature only)
//   pix_valid         1 = active video, 0 = blanking (output forced black)
//   frame_start       one-cycle pulse per frame: palette commit, blink step
//   blink_mask        per-index blink enable, latched on frame_start
//   pal_wr_valid/ready, pal_wr_idx, pal_wr_rgb   palette write handshake
//   VGA_R/G/B         registered colour outputs
// ---------------------------------------------------------------------------
module palette_color_mapper
  import palette_pkg::*;
#(
  parameter  int IDX_W        = 3,
  parameter  int CHAN_W       = 8,
  parameter  int BLINK_FRAMES = 16,
  parameter  int CELL_SIZE    = 16,
  localparam int NUM_COLORS   = 2 ** IDX_W
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [IDX_W-1:0]      color,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic                  pix_valid,
  input  logic                  frame_start,
  input  logic [NUM_COLORS-1:0] blink_mask,
  input  logic                  pal_wr_valid,
  output logic                  pal_wr_ready,
  input  logic [IDX_W-1:0]      pal_wr_idx,
  input  logic [3*CHAN_W-1:0]   pal_wr_rgb,
  output logic [CHAN_W-1:0]     VGA_R,
  output logic [CHAN_W-1:0]     VGA_G,
  output logic [CHAN_W-1:0]     VGA_B
);

  localparam int              CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [IDX_W-1:0] BG_IDX   = IDX_W'(COL_BG);

  // ---------------- blink phase tracking ----------------
  logic [CNT_W-1:0]      frame_cnt;
  logic                  blink_hidden;
  logic [NUM_COLORS-1:0] mask_latched;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_cnt    <= '0;
      blink_hidden <= 1'b0;
      mask_latched <= '0;
    end else if (frame_start) begin
      mask_latched <= blink_mask;
      if (frame_cnt == CNT_LAST) begin
        frame_cnt    <= '0;
        blink_hidden <= ~blink_hidden;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // ---------------- stage 1: index capture ----------------
  logic [IDX_W-1:0] s1_idx;
  logic             s1_valid;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_idx   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_idx   <= color;
      s1_valid <= pix_valid;
    end
  end

  // ---------------- palette lookup ----------------
  logic [IDX_W-1:0]    lookup_idx;
  logic [3*CHAN_W-1:0] lookup_rgb;
  logic [3*CHAN_W-1:0] pix_rgb;

  // Hidden-phase blinking pixels show the background entry; the phase and
  // mask are sampled alongside the pixel in stage 2, so a pixel already in
  // flight when frame_start fires still uses the previous frame's settings.
  assign lookup_idx = (blink_hidden && mask_latched[s1_idx]) ? BG_IDX : s1_idx;

  palette_regfile #(
    .IDX_W  (IDX_W),
    .CHAN_W (CHAN_W)
  ) u_regfile (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .commit   (frame_start),
    .wr_valid (pal_wr_valid),
    .wr_ready (pal_wr_ready),
    .wr_idx   (pal_wr_idx),
    .wr_rgb   (pal_wr_rgb),
    .rd_idx   (lookup_idx),
    .rd_rgb   (lookup_rgb)
  );

`ifdef PALETTE_GRID_LINES_EN
  // Coordinates ride along with the index so the grid stays pixel-aligned.
  logic [9:0] s1_x;
  logic [9:0] s1_y;
  logic       on_grid;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_x <= '0;
      s1_y <= '0;
    end else begin
      s1_x <= DrawX;
      s1_y <= DrawY;
    end
  end

  assign on_grid = ((int'(s1_x) % CELL_SIZE) == 0) || ((int'(s1_y) % CELL_SIZE) == 0);

  always_comb begin
    pix_rgb = lookup_rgb;
    if (on_grid) begin
      for (int c = 0; c < 3; c++) begin
        pix_rgb[c*CHAN_W +: CHAN_W] = lookup_rgb[c*CHAN_W +: CHAN_W] >> 1;
      end
    end
  end
`else
  logic            unused_draw;
  localparam int   UNUSED_CELL_SIZE = CELL_SIZE;
  assign unused_draw = ^{DrawX, DrawY};
  assign pix_rgb     = lookup_rgb;
`endif

  // ---------------- stage 2: registered output ----------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end else if (!s1_valid) begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end else begin
      VGA_R <= pix_rgb[2*CHAN_W +: CHAN_W];
      VGA_G <= pix_rgb[1*CHAN_W +: CHAN_W];
      VGA_B <= pix_rgb[0*CHAN_W +: CHAN_W];
    end
  end

endmodule

// File: tb/tb_palette_color_mapper.sv
// ---------------------------------------------------------------------------
// tb_palette_color_mapper
// Self-checking bench: a vector table for the basic colour mapping and
// blanking, hand-written sequences for commit, commit stall, blink and
// reset-during-write, then randomized traffic against a frame-level model.
// ---------------------------------------------------------------------------
module tb_palette_color_mapper;

  localparam int BF   = 2;
  localparam int CELL = 16;

  logic        Clk;
  logic        Reset_n;
  logic [2:0]  color;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        pix_valid;
  logic        frame_start;
  logic [7:0]  blink_mask;
  logic        pal_wr_valid;
  logic        pal_wr_ready;
  logic [2:0]  pal_wr_idx;
  logic [23:0] pal_wr_rgb;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;

  palette_color_mapper #(
    .IDX_W        (3),
    .CHAN_W       (8),
    .BLINK_FRAMES (BF),
    .CELL_SIZE    (CELL)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .color        (color),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .pix_valid    (pix_valid),
    .frame_start  (frame_start),
    .blink_mask   (blink_mask),
    .pal_wr_valid (pal_wr_valid),
    .pal_wr_ready (pal_wr_ready),
    .pal_wr_idx   (pal_wr_idx),
    .pal_wr_rgb   (pal_wr_rgb),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [23:0] m_shadow [8];
  logic [23:0] m_active [8];
  logic [7:0]  m_mask;
  int          m_frames;
  logic        m_s1_valid;
  logic [2:0]  m_s1_idx;
  logic [23:0] m_out;
`ifdef PALETTE_GRID_LINES_EN
  logic [9:0]  m_s1_x;
  logic [9:0]  m_s1_y;
`endif

  function automatic logic [23:0] default_rgb(input int idx);
    case (idx)
      1:       return 24'hFF0000;
      2:       return 24'h00FF00;
      3:       return 24'h0000FF;
      4:       return 24'h7F7F00;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  // Blink phase from the number of frame starts seen since reset:
  // phase flips once every BF frames.
  function automatic bit hidden_phase(input int frames);
    return ((frames / BF) % 2) == 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = default_rgb(i);
      m_active[i] = default_rgb(i);
    end
    m_mask     = '0;
    m_frames   = 0;
    m_s1_valid = 1'b0;
    m_s1_idx   = '0;
    m_out      = '0;
`ifdef PALETTE_GRID_LINES_EN
    m_s1_x = '0;
    m_s1_y = '0;
`endif
  endtask

  // One clock edge: output comes from the pixel captured last edge using the
  // palette/blink state as it stood before this edge; then state advances.
  task automatic model_edge();
    logic [2:0]  sel;
    logic [23:0] v;
    if (!m_s1_valid) begin
      m_out = '0;
    end else begin
      sel = (hidden_phase(m_frames) && m_mask[m_s1_idx]) ? 3'd0 : m_s1_idx;
      v   = m_active[sel];
`ifdef PALETTE_GRID_LINES_EN
      if ((m_s1_x % CELL) == 0 || (m_s1_y % CELL) == 0)
        v = {1'b0, v[23:17], 1'b0, v[15:9], 1'b0, v[7:1]};
`endif
      m_out = v;
    end
    m_s1_valid = pix_valid;
    m_s1_idx   = color;
`ifdef PALETTE_GRID_LINES_EN
    m_s1_x = DrawX;
    m_s1_y = DrawY;
`endif
    if (frame_start) begin
      for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
      m_mask   = blink_mask;
      m_frames = m_frames + 1;
    end else if (pal_wr_valid) begin
      m_shadow[pal_wr_idx] = pal_wr_rgb;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    if (!Reset_n) model_reset();
    else          model_edge();
    #1;
  endtask

  task automatic check_rgb(input string name, input logic [23:0] exp);
    logic [23:0] got;
    got   = {VGA_R, VGA_G, VGA_B};
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%06h exp=%06h", name, got, exp);
    end else begin
      $display("ok   %s rgb=%06h", name, got);
    end
  endtask

  task automatic check_ready(input string name, input logic exp);
    n_cmp = n_cmp + 1;
    if (pal_wr_ready !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s ready got=%b exp=%b", name, pal_wr_ready, exp);
    end else begin
      $display("ok   %s ready=%b", name, pal_wr_ready);
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        valid;
    logic [2:0]  color;
    logic [23:0] exp;
  } vec_t;

  vec_t vt [7];

  initial begin
    Reset_n      = 1'b0;
    color        = '0;
    DrawX        = 10'd33;
    DrawY        = 10'd5;
    pix_valid    = 1'b0;
    frame_start  = 1'b0;
    blink_mask   = '0;
    pal_wr_valid = 1'b0;
    pal_wr_idx   = '0;
    pal_wr_rgb   = '0;
    model_reset();

    vt[0] = '{1'b1, 3'd1, 24'hFF0000};
    vt[1] = '{1'b1, 3'd2, 24'h00FF00};
    vt[2] = '{1'b1, 3'd3, 24'h0000FF};
    vt[3] = '{1'b1, 3'd4, 24'h7F7F00};
    vt[4] = '{1'b1, 3'd7, 24'hFFFFFF};
    vt[5] = '{1'b0, 3'd1, 24'h000000};
    vt[6] = '{1'b1, 3'd0, 24'hFFFFFF};

    // Reset state
    tick();
    tick();
    check_rgb("reset_rgb", 24'h000000);
    check_ready("reset_ready", 1'b1);
    Reset_n = 1'b1;

    // Table: colour mapping and blanking, latency 2
    for (int i = 0; i <= 7; i++) begin
      if (i < 7) begin
        pix_valid = vt[i].valid;
        color     = vt[i].color;
      end
      tick();
      if (i >= 1) check_rgb($sformatf("vec%0d_idx%0d", i - 1, vt[i-1].color), vt[i-1].exp);
    end

`ifdef PALETTE_GRID_LINES_EN
    pix_valid = 1'b1; color = 3'd1; DrawX = 10'd32; DrawY = 10'd5;
    tick(); tick();
    check_rgb("grid_on_x32", 24'h7F0000);
    DrawX = 10'd33;
    tick(); tick();
    check_rgb("grid_off_x33", 24'hFF0000);
`endif

    // Commit: mid-frame write is invisible until the next frame_start
    pix_valid = 1'b1; color = 3'd2;
    pal_wr_valid = 1'b1; pal_wr_idx = 3'd2; pal_wr_rgb = 24'h0A141E;
    tick();
    pal_wr_valid = 1'b0;
    tick(); tick();
    check_rgb("commit_before", 24'h00FF00);
    pulse_frame();
    check_rgb("commit_inflight", 24'h00FF00);
    tick();
    check_rgb("commit_after", 24'h0A141E);

    // Commit stall: write held across frame_start accepted one cycle later
    color = 3'd5;
    pal_wr_valid = 1'b1; pal_wr_idx = 3'd5; pal_wr_rgb = 24'h010203;
    frame_start = 1'b1;
    #1 check_ready("stall_fs_cycle", 1'b0);
    tick();
    frame_start = 1'b0;
    #1 check_ready("stall_next_cycle", 1'b1);
    tick();
    pal_wr_valid = 1'b0;
    tick(); tick();
    check_rgb("stall_not_yet", 24'hFFFFFF);
    pulse_frame();
    tick();
    check_rgb("stall_committed", 24'h010203);

    // Reset during a write: everything back to defaults, write lost
    pal_wr_valid = 1'b1; pal_wr_idx = 3'd1; pal_wr_rgb = 24'h090909;
    color = 3'd1;
    tick();
    #2 Reset_n = 1'b0;
    model_reset();
    #1 check_rgb("async_reset_clear", 24'h000000);
    tick();
    pal_wr_valid = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick(); tick();
    check_rgb("reset_write_discarded", 24'hFF0000);
    pulse_frame();
    tick(); tick();
    check_rgb("reset_write_discarded_commit", 24'hFF0000);

    // Blink from a fresh reset: idx1 blinks every BF frames, idx3 never
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    blink_mask = 8'b0000_0010;
    for (int f = 1; f <= 6; f++) begin
      color = 3'd1;
      pulse_frame();
      tick(); tick();
      check_rgb($sformatf("blink_f%0d_idx1", f),
                hidden_phase(f) ? 24'hFFFFFF : 24'hFF0000);
      color = 3'd3;
      tick(); tick();
      check_rgb($sformatf("blink_f%0d_idx3", f), 24'h0000FF);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 1000; c++) begin
      pix_valid    = ($urandom_range(0, 3) != 0);
      color        = 3'($urandom_range(0, 7));
      frame_start  = ($urandom_range(0, 15) == 0);
      blink_mask   = 8'($urandom);
      pal_wr_valid = ($urandom_range(0, 2) == 0);
      pal_wr_idx   = 3'($urandom_range(0, 7));
      pal_wr_rgb   = 24'($urandom);
      DrawX        = 10'($urandom_range(0, 639));
      DrawY        = 10'($urandom_range(0, 479));
      #1 check_ready($sformatf("rand%0d", c), ~frame_start);
      tick();
      check_rgb($sformatf("rand%0d", c), m_out);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
